// File: rtl/mips_if_pkg.sv
// Shared constants and the next-PC select encoding for the MIPS fetch stage.
package mips_if_pkg;

    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef enum logic [1:0] {
        PC_SEQ,
        PC_HOLD,
        PC_BRANCH,
        PC_JUMP
    } pc_sel_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush squashes to a NOP bubble, hold freezes all fields.
module if_id_reg #(
    parameter logic [31:0] NOP_WORD = mips_if_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] d_instr,
    input  logic [31:0] d_pc_plus4,
    input  logic        d_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    // Flush beats hold so a redirect always kills the wrong-path fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= NOP_WORD;
            pc_plus4 <= 32'h0000_0000;
            valid    <= 1'b0;
        end else if (flush) begin
            instr    <= NOP_WORD;
            pc_plus4 <= 32'h0000_0000;
            valid    <= 1'b0;
        end else if (!hold) begin
            instr    <= d_instr;
            pc_plus4 <= d_pc_plus4;
            valid    <= d_valid;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC register, next-PC select, fault flagging and IF/ID register.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = mips_if_pkg::RESET_PC,
    parameter int unsigned IMEM_WORDS = 1024,
    parameter logic [31:0] NOP_WORD   = mips_if_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        fetch_err,
    output logic [31:0] fetch_count
);

    import mips_if_pkg::*;

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

    pc_sel_e     pc_sel;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic        redirect;
    logic        misaligned;
    logic        advance;
    logic        out_of_range;
    logic        fault;
    logic        capture_valid;
    logic [31:0] d_instr;

    assign imem_addr     = pc;
    assign pc_plus4      = pc + WORD_BYTES;
    assign jump_target   = {ifid_pc_plus4[31:28], jump_index, 2'b00};
    assign redirect      = branch_taken | jump;
    assign advance       = !redirect && !stall;
    assign out_of_range  = ({2'b00, pc[31:2]} >= IMEM_LIMIT);
    assign fault         = advance && out_of_range;
    assign capture_valid = advance && !out_of_range;
    assign d_instr       = fault ? NOP_WORD : imem_instr;

    // Branch (older, in EX) outranks jump (in ID); any redirect outranks stall.
    always_comb begin
        pc_sel = PC_SEQ;
        if (branch_taken)
            pc_sel = PC_BRANCH;
        else if (jump)
            pc_sel = PC_JUMP;
        else if (stall)
            pc_sel = PC_HOLD;
    end

    // Redirect targets are force-aligned; the low bits only feed the fault flag.
    always_comb begin
        misaligned = 1'b0;
        pc_next    = pc_plus4;
        case (pc_sel)
            PC_BRANCH: begin
                pc_next    = {branch_target[31:2], 2'b00};
                misaligned = (branch_target[1:0] != 2'b00);
            end
            PC_JUMP:   pc_next = jump_target;
            PC_HOLD:   pc_next = pc;
            default:   pc_next = pc_plus4;
        endcase
    end

    // PC register; an out-of-range fetch still advances sequentially.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else
            pc <= pc_next;
    end

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_err <= 1'b0;
        else if (misaligned || fault)
            fetch_err <= 1'b1;
    end

    // Counts every edge that writes a valid instruction into IF/ID; wraps freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_count <= 32'h0000_0000;
        else if (capture_valid)
            fetch_count <= fetch_count + 32'd1;
    end

    if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (stall),
        .flush      (redirect),
        .d_instr    (d_instr),
        .d_pc_plus4 (pc_plus4),
        .d_valid    (!fault),
        .instr      (ifid_instr),
        .pc_plus4   (ifid_pc_plus4),
        .valid      (ifid_valid)
    );

endmodule
